alu_cmd_issuer: RTL and testbench

Command-side front end for the combinational `alu`. It accepts ALU commands over a valid/ready channel and buffers them in a small FIFO. Each command is presented to the ALU's `op`/`a`/`b` inputs, and the result with its Z/N/C/V flags is captured into a response register behind a second valid/ready channel. It sits between a command producer (sequencer or bus adapter) and the ALU. It turns the ALU's untimed combinational interface into an ordered, back-pressured request/response stream, with optional per-opcode hit counters.

---
 rtl/alu_cmd_issuer.sv | 143 ++++++++++++++
 tb/tb_alu_cmd_issuer.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_issuer.sv
// Command FIFO and response register in front of a combinational ALU.
// Define ALU_ISSUER_OPCOUNT_EN to build the saturating per-opcode hit counters.
module alu_cmd_issuer #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [2:0]         cmd_op,
  input  logic [31:0]        cmd_a,
  input  logic [31:0]        cmd_b,
  output logic [2:0]         alu_op,
  output logic [31:0]        alu_a,
  output logic [31:0]        alu_b,
  input  logic [31:0]        alu_y,
  input  logic               alu_z,
  input  logic               alu_n,
  input  logic               alu_c,
  input  logic               alu_v,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [31:0]        rsp_y,
  output logic [3:0]         rsp_flags,
  output logic [2:0]         rsp_op,
  output logic               rsp_err,
  output logic               busy,
  input  logic               cnt_clr,
  output logic [6*CNT_W-1:0] op_hits
);
  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } cmd_t;

  cmd_t        mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic        empty, full, push, issue, legal;
  cmd_t        head;

  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_y_q, rsp_y_d;
  logic [3:0]  rsp_flags_q, rsp_flags_d;
  logic [2:0]  rsp_op_q, rsp_op_d;
  logic        rsp_err_q, rsp_err_d;

  // The extra pointer MSB separates full (wrap bits differ) from empty.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign cmd_ready = !full;
  assign push      = cmd_valid && !full;
  assign issue     = !empty && (!rsp_valid_q || rsp_ready);

  assign head   = mem_q[rd_ptr_q[AW-1:0]];
  assign legal  = (head.op <= 3'd5);
  assign alu_op = empty ? 3'd0  : head.op;
  assign alu_a  = empty ? 32'd0 : head.a;
  assign alu_b  = empty ? 32'd0 : head.b;

  // NOTE: payload storage has no reset; only the pointers decide what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= '{op: cmd_op, a: cmd_a, b: cmd_b};
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no latch is inferred.
    rsp_valid_d = rsp_valid_q;
    rsp_y_d     = rsp_y_q;
    rsp_flags_d = rsp_flags_q;
    rsp_op_d    = rsp_op_q;
    rsp_err_d   = rsp_err_q;
    if (issue) begin
      rsp_valid_d = 1'b1;
      rsp_y_d     = legal ? alu_y : 32'd0;
      rsp_flags_d = legal ? {alu_z, alu_n, alu_c, alu_v} : 4'd0;
      rsp_op_d    = head.op;
      rsp_err_d   = !legal;
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_y_q     <= '0;
      rsp_flags_q <= '0;
      rsp_op_q    <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      if (push)  wr_ptr_q <= wr_ptr_q + 1'b1;
      if (issue) rd_ptr_q <= rd_ptr_q + 1'b1;
      rsp_valid_q <= rsp_valid_d;
      rsp_y_q     <= rsp_y_d;
      rsp_flags_q <= rsp_flags_d;
      rsp_op_q    <= rsp_op_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_y     = rsp_y_q;
  assign rsp_flags = rsp_flags_q;
  assign rsp_op    = rsp_op_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = !empty || rsp_valid_q;

`ifdef ALU_ISSUER_OPCOUNT_EN
  logic [CNT_W-1:0] cnt_q [6];

  // Clear wins over a same-edge increment; counters stick at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 6; k++) cnt_q[k] <= '0;
    end else if (cnt_clr) begin
      for (int k = 0; k < 6; k++) cnt_q[k] <= '0;
    end else if (issue && legal) begin
      for (int k = 0; k < 6; k++) begin
        if (head.op == 3'(k) && cnt_q[k] != '1) cnt_q[k] <= cnt_q[k] + 1'b1;
      end
    end
  end

  always_comb begin
    op_hits = '0;
    for (int k = 0; k < 6; k++) op_hits[k*CNT_W +: CNT_W] = cnt_q[k];
  end
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign op_hits        = '0;
`endif

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Bench for alu_cmd_issuer: reference ALU stub, queue-based model, directed and random traffic.
// A second instance with 2-bit counters exercises saturation.
module tb_alu_cmd_issuer;
  localparam int DEPTH = 4;
  localparam int CNT_W = 16;
  localparam int SAT_W = 2;
`ifdef ALU_ISSUER_OPCOUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic clk, rst;
  logic cmd_valid, cmd_ready, rsp_ready, cnt_clr;
  logic [2:0] cmd_op, alu_op, rsp_op;
  logic [31:0] cmd_a, cmd_b, alu_a, alu_b, alu_y, rsp_y;
  logic alu_z, alu_n, alu_c, alu_v, rsp_valid, rsp_err, busy;
  logic [3:0] rsp_flags;
  logic [6*CNT_W-1:0] op_hits;

  logic s_cmd_ready, s_rsp_valid, s_rsp_err, s_busy;
  logic [2:0] s_alu_op, s_rsp_op;
  logic [31:0] s_alu_a, s_alu_b, s_rsp_y;
  logic [3:0] s_rsp_flags;
  logic [6*SAT_W-1:0] s_op_hits;

  int n_checks = 0;
  int n_err = 0;
  int cyc = 0;

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } cmd_t;

  typedef struct {
    logic [31:0] y;
    logic [3:0]  f;
    logic [2:0]  op;
    logic        err;
    int          cyc;
  } rsp_rec_t;

  // Reference ALU: {y, z, n, c, v}. Illegal opcodes return junk so zeroing is visible.
  function automatic logic [35:0] ref_alu(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [32:0] s;
    logic [31:0] y;
    logic c, v;
    c = 1'b0;
    v = 1'b0;
    case (op)
      3'd0: begin
        s = {1'b0, a} + {1'b0, b};
        y = s[31:0];
        c = s[32];
        v = (a[31] == b[31]) && (y[31] != a[31]);
      end
      3'd1: begin
        y = a - b;
        c = (a >= b);
        v = (a[31] != b[31]) && (y[31] != a[31]);
      end
      3'd2: y = a & b;
      3'd3: y = a | b;
      3'd4: y = a ^ b;
      3'd5: y = {31'd0, $signed(a) < $signed(b)};
      default: return {a + b + 32'hDEAD, 4'hF};
    endcase
    return {y, (y == 32'd0), y[31], c, v};
  endfunction

  assign {alu_y, alu_z, alu_n, alu_c, alu_v} = ref_alu(alu_op, alu_a, alu_b);

  alu_cmd_issuer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_y(alu_y), .alu_z(alu_z), .alu_n(alu_n), .alu_c(alu_c), .alu_v(alu_v),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_y(rsp_y), .rsp_flags(rsp_flags),
    .rsp_op(rsp_op), .rsp_err(rsp_err), .busy(busy), .cnt_clr(cnt_clr), .op_hits(op_hits)
  );

  alu_cmd_issuer #(.DEPTH(DEPTH), .CNT_W(SAT_W)) dut_sat (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(s_cmd_ready),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .alu_op(s_alu_op), .alu_a(s_alu_a), .alu_b(s_alu_b),
    .alu_y(alu_y), .alu_z(alu_z), .alu_n(alu_n), .alu_c(alu_c), .alu_v(alu_v),
    .rsp_valid(s_rsp_valid), .rsp_ready(rsp_ready), .rsp_y(s_rsp_y), .rsp_flags(s_rsp_flags),
    .rsp_op(s_rsp_op), .rsp_err(s_rsp_err), .busy(s_busy), .cnt_clr(cnt_clr),
    .op_hits(s_op_hits)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a queue of pending commands, one response slot, unbounded hit tallies.
  cmd_t        mq[$];
  bit          m_v;
  logic [31:0] m_y;
  logic [3:0]  m_f;
  logic [2:0]  m_op;
  logic        m_err;
  int unsigned m_cnt [6];

  always @(posedge clk or posedge rst) begin : model
    bit do_push, do_issue;
    cmd_t c;
    if (rst) begin
      mq.delete();
      m_v = 0; m_y = '0; m_f = '0; m_op = '0; m_err = 1'b0;
      foreach (m_cnt[k]) m_cnt[k] = 0;
    end else begin
      do_push  = cmd_valid && (mq.size() < DEPTH);
      do_issue = (mq.size() > 0) && (!m_v || rsp_ready);
      if (cnt_clr) foreach (m_cnt[k]) m_cnt[k] = 0;
      if (do_issue) begin
        c = mq.pop_front();
        m_op  = c.op;
        m_err = (c.op > 3'd5);
        if (m_err) {m_y, m_f} = '0;
        else {m_y, m_f} = ref_alu(c.op, c.a, c.b);
        m_v = 1;
        if (!m_err && !cnt_clr) m_cnt[int'(c.op)]++;
      end else if (rsp_ready) begin
        m_v = 0;
      end
      if (do_push) mq.push_back('{op: cmd_op, a: cmd_a, b: cmd_b});
    end
  end

  function automatic logic [95:0] exp_hits16();
    logic [95:0] r;
    r = '0;
    for (int k = 0; k < 6; k++) r[k*16 +: 16] = (m_cnt[k] > 65535) ? 16'hFFFF : 16'(m_cnt[k]);
    return CNT_EN ? r : 96'd0;
  endfunction

  function automatic logic [11:0] exp_hits2();
    logic [11:0] r;
    r = '0;
    for (int k = 0; k < 6; k++) r[k*2 +: 2] = (m_cnt[k] > 3) ? 2'd3 : 2'(m_cnt[k]);
    return CNT_EN ? r : 12'd0;
  endfunction

  always @(negedge clk) begin : compare
    logic [66:0] exp_alu;
    if (!rst) begin
      exp_alu = (mq.size() > 0) ? mq[0] : 67'd0;
      check("cmd_ready", cmd_ready, mq.size() < DEPTH);
      check("busy", busy, (mq.size() > 0) || m_v);
      check("rsp_valid", rsp_valid, m_v);
      check("alu_drive", {alu_op, alu_a, alu_b}, exp_alu);
      check("op_hits", op_hits, exp_hits16());
      check("sat_ctrl", {s_cmd_ready, s_busy, s_rsp_valid, s_alu_op, s_alu_a, s_alu_b},
            {mq.size() < DEPTH, (mq.size() > 0) || m_v, m_v, exp_alu});
      check("sat_op_hits", s_op_hits, exp_hits2());
      if (m_v) begin
        check("rsp_fields", {rsp_op, rsp_err, rsp_y, rsp_flags}, {m_op, m_err, m_y, m_f});
        check("sat_rsp_fields", {s_rsp_op, s_rsp_err, s_rsp_y, s_rsp_flags},
              {m_op, m_err, m_y, m_f});
      end
    end
  end

  // Transaction log used by the directed literal checks.
  rsp_rec_t got_q[$];
  int       acc_log[$];
  always @(negedge clk) begin
    if (!rst) begin
      if (cmd_valid && cmd_ready) acc_log.push_back(cyc);
      if (rsp_valid && rsp_ready) got_q.push_back('{rsp_y, rsp_flags, rsp_op, rsp_err, cyc});
    end
  end

  task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bit acc;
    int n;
    acc = 0;
    n = 0;
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = cmd_ready;
      @(posedge clk);
      #1;
      n++;
    end
    cmd_valid = 1'b0;
    if (!acc) check("send_timeout", acc, 1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_idle", busy, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_clr();
    cnt_clr = 1'b1;
    @(posedge clk);
    #1 cnt_clr = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, abase, idx, acc_n, rsp_base, cyc_n;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0;
    rsp_ready = 1'b0; cnt_clr = 1'b0;

    #1;
    check("reset_cmd_ready", cmd_ready, 1);
    check("reset_outputs", {rsp_valid, rsp_err, busy, rsp_y, rsp_flags, rsp_op}, 0);
    check("reset_op_hits", op_hits, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;

    // Three commands back to back, responses drained immediately.
    rsp_ready = 1'b1;
    base = got_q.size();
    abase = acc_log.size();
    send(3'd0, 32'd2, 32'd3);
    send(3'd1, 32'd7, 32'd7);
    send(3'd5, 32'hFFFF_FFFF, 32'd1);
    wait_idle();
    check("seq_count", got_q.size() - base, 3);
    check("seq_add_y", got_q[base].y, 32'd5);
    check("seq_sub_y", got_q[base+1].y, 32'd0);
    check("seq_sub_z", got_q[base+1].f[3], 1'b1);
    check("seq_slt_y", got_q[base+2].y, 32'd1);
    check("seq_latency", got_q[base].cyc, acc_log[abase] + 2);
    check("seq_consec1", got_q[base+1].cyc, got_q[base].cyc + 1);
    check("seq_consec2", got_q[base+2].cyc, got_q[base+1].cyc + 1);

    // Back-pressure: DEPTH in the FIFO plus one in the response slot.
    rsp_ready = 1'b0;
    base = got_q.size();
    idx = 0;
    for (int k = 0; k < 12 && idx < 8; k++) begin
      cmd_valid = 1'b1; cmd_op = 3'd4; cmd_a = 32'h100 + 32'(idx); cmd_b = 32'hF0F0_0000;
      @(negedge clk);
      if (cmd_ready) idx++;
      @(posedge clk);
      #1;
    end
    cmd_valid = 1'b0;
    check("bp_accepts", idx, 5);
    @(negedge clk);
    check("bp_ready_low", cmd_ready, 0);
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_ready_reassert", cmd_ready, 1);
    wait_idle();
    check("bp_count", got_q.size() - base, 5);
    for (int i = 0; i < 5; i++) begin
      check("bp_y", got_q[base+i].y, 32'hF0F0_0100 + 32'(i));
      check("bp_flags", got_q[base+i].f, 4'b0100);
      if (i > 0) check("bp_consec", got_q[base+i].cyc, got_q[base+i-1].cyc + 1);
    end

    // Illegal opcode sandwiched between two adds.
    pulse_clr();
    base = got_q.size();
    send(3'd0, 32'd10, 32'd20);
    send(3'd7, 32'd1, 32'd1);
    send(3'd0, 32'd5, 32'd6);
    wait_idle();
    check("ill_count", got_q.size() - base, 3);
    check("ill_first", {got_q[base].err, got_q[base].y}, {1'b0, 32'd30});
    check("ill_mid", {got_q[base+1].err, got_q[base+1].op, got_q[base+1].y, got_q[base+1].f},
          {1'b1, 3'd7, 32'd0, 4'd0});
    check("ill_last", {got_q[base+2].err, got_q[base+2].y}, {1'b0, 32'd11});
    check("ill_hits", op_hits, CNT_EN ? 96'h2 : 96'h0);

    // Counters: 3 ADD + 1 XOR, then a clear coinciding with an issue, then saturation.
    pulse_clr();
    send(3'd0, 32'd1, 32'd1);
    send(3'd0, 32'd2, 32'd2);
    send(3'd4, 32'd3, 32'd3);
    send(3'd0, 32'd4, 32'd4);
    wait_idle();
    check("cnt_hits", op_hits, CNT_EN ? 96'h0000_0001_0000_0000_0000_0003 : 96'h0);
    check("cnt_hits_sat", s_op_hits, CNT_EN ? 12'h103 : 12'h0);
    send(3'd0, 32'd9, 32'd9);
    cnt_clr = 1'b1;
    @(posedge clk);
    #1 cnt_clr = 1'b0;
    wait_idle();
    check("cnt_clr_wins", op_hits, 0);
    for (int i = 0; i < 5; i++) send(3'd0, 32'(i), 32'd1);
    wait_idle();
    check("cnt_five", op_hits, CNT_EN ? 96'h5 : 96'h0);
    check("cnt_saturate", s_op_hits, CNT_EN ? 12'h3 : 12'h0);

    // Asynchronous reset mid-stream.
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(3'd2, 32'hFF00 + 32'(i), 32'h0F0F);
    check("pre_rst_busy", {busy, rsp_valid}, 2'b11);
    #2 rst = 1'b1;
    #1;
    check("rst_async_out", {rsp_valid, busy}, 2'b00);
    check("rst_async_ready", cmd_ready, 1);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    rsp_ready = 1'b1;
    base = got_q.size();
    repeat (5) @(posedge clk);
    #1;
    check("no_stale_rsp", got_q.size() - base, 0);
    check("post_rst_busy", busy, 0);

    // Random traffic.
    rsp_base = got_q.size();
    abase = acc_log.size();
    acc_n = 0;
    cyc_n = 0;
    while (acc_n < 2000 && cyc_n < 30000) begin
      cmd_valid = ($urandom_range(0, 3) != 0);
      cmd_op    = 3'($urandom_range(0, 7));
      cmd_a     = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      cmd_b     = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      rsp_ready = ($urandom_range(0, 2) != 0);
      cnt_clr   = ($urandom_range(0, 199) == 0);
      @(negedge clk);
      if (cmd_valid && cmd_ready) acc_n++;
      @(posedge clk);
      #1;
      cyc_n++;
    end
    cmd_valid = 1'b0;
    cnt_clr = 1'b0;
    rsp_ready = 1'b1;
    wait_idle();
    check("rand_accepts", acc_n, 2000);
    check("rand_rsp_eq_acc", got_q.size() - rsp_base, acc_log.size() - abase);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
